// File: rtl/result_writeback.sv
// result_writeback
//   Captures per-lane MAC results and serialises them into the output memory,
//   one word per cycle, starting at a programmable base address. Asserts done
//   for one cycle once n_words words have been written.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start               arm the block (honoured only while idle)
//   base_addr, n_words  first write address and word count, latched on start
//   acc_in_0..3         lane results; valid_in[i] qualifies acc_in_i
//   mem_we/addr/wdata   write port to the result RAM
//   busy                block is not idle
//   done                one-cycle completion pulse
//   overflow            sticky: results arrived while draining and were dropped
//   wr_count            words written in the current/last run
module result_writeback #(
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned N_MACS = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   n_words,
  input  logic [ACC_W-1:0]  acc_in_0,
  input  logic [ACC_W-1:0]  acc_in_1,
  input  logic [ACC_W-1:0]  acc_in_2,
  input  logic [ACC_W-1:0]  acc_in_3,
  input  logic [N_MACS-1:0] valid_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ACC_W-1:0]  mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   wr_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     target_q, target_d;
  logic [ADDR_W:0]     wr_count_q, wr_count_d;
  logic                overflow_q, overflow_d;
  logic [N_MACS-1:0]   pending_q, pending_d;
  logic [ACC_W-1:0]    buf_q [N_MACS];
  logic [ACC_W-1:0]    buf_d [N_MACS];

  logic [ACC_W-1:0]    acc_lane [N_MACS];
  logic [ACC_W-1:0]    drain_data;

  always_comb begin
    for (int unsigned i = 0; i < N_MACS; i++) begin
      if (i == 0)      acc_lane[i] = acc_in_0;
      else if (i == 1) acc_lane[i] = acc_in_1;
      else if (i == 2) acc_lane[i] = acc_in_2;
      else             acc_lane[i] = acc_in_3;
    end
  end

  // Scan from the top lane down so the lowest set pending bit wins.
  always_comb begin
    drain_data = '0;
    for (int unsigned i = 0; i < N_MACS; i++) begin
      if (pending_q[N_MACS-1-i]) drain_data = buf_q[N_MACS-1-i];
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    target_d   = target_q;
    wr_count_d = wr_count_q;
    overflow_d = overflow_q;
    pending_d  = pending_q;
    buf_d      = buf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          target_d   = n_words;
          wr_count_d = '0;
          overflow_d = 1'b0;
          pending_d  = '0;
          state_d    = (n_words == '0) ? S_DONE : S_ARMED;
        end
      end
      S_ARMED: begin
        if (valid_in != '0) begin
          pending_d = valid_in;
          for (int unsigned i = 0; i < N_MACS; i++) begin
            if (valid_in[i]) buf_d[i] = acc_lane[i];
          end
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (valid_in != '0) overflow_d = 1'b1;
        // x & (x-1) clears the lowest set bit: the lane written this cycle.
        pending_d  = pending_q & (pending_q - 1'b1);
        addr_d     = addr_q + 1'b1;
        wr_count_d = wr_count_q + 1'b1;
        if (wr_count_d == target_q) begin
          pending_d = '0;
          state_d   = S_DONE;
        end else if (pending_d == '0) begin
          state_d = S_ARMED;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      target_q   <= '0;
      wr_count_q <= '0;
      overflow_q <= 1'b0;
      pending_q  <= '0;
      for (int unsigned i = 0; i < N_MACS; i++) buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      target_q   <= target_d;
      wr_count_q <= wr_count_d;
      overflow_q <= overflow_d;
      pending_q  <= pending_d;
      for (int unsigned i = 0; i < N_MACS; i++) buf_q[i] <= buf_d[i];
    end
  end

  always_comb begin
    mem_we    = (state_q == S_DRAIN);
    mem_addr  = addr_q;
    mem_wdata = (state_q == S_DRAIN) ? drain_data : '0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    overflow  = overflow_q;
    wr_count  = wr_count_q;
  end

endmodule
